vm_vend_ctrl: RTL and testbench

Transaction controller that sequences the vending datapath. It captures coin events from the nickel and dime buttons and buffers them in a small coin FIFO. It credits coins to the balance one per cycle, runs the dispense handshake with the product motor when the price is met, and returns change as nickels over a second handshake on cancel. It sits between the button inputs and the balance/LED display logic, replacing direct button-to-accumulator wiring.

---
 rtl/vm_pkg.sv | 24 ++
 rtl/vm_coin_fifo.sv | 70 +++++++
 rtl/vm_vend_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_vm_vend_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending transaction controller.
package vm_pkg;

    // Controller states; encoding 2'd3 is never produced and is recovered to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } vm_state_t;

    // Coin values in cents.
    localparam int NICKEL = 5;
    localparam int DIME   = 10;

    // Default item price in cents.
    localparam int DEFAULT_PRICE = 25;

    // One queued coin, value in cents.
    typedef logic [4:0] coin_t;

    localparam coin_t COIN_NICKEL = coin_t'(NICKEL);
    localparam coin_t COIN_DIME   = coin_t'(DIME);

endpackage

// File: rtl/vm_coin_fifo.sv
// Coin FIFO: first-word fall-through queue of coin_t.
// Accepts up to two writes per cycle (slot a is older than slot b) and one read.
// The writer is responsible for never exceeding the free space.
module vm_coin_fifo
    import vm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push_a,
    input  coin_t                    i_data_a,
    input  logic                     i_push_b,
    input  coin_t                    i_data_b,
    input  logic                     i_pop,
    output coin_t                    o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    coin_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_wr_ptr_b;
    logic [AW:0]   w_push_n;

    // Slot for the second write and number of entries written this cycle.
    always_comb begin
        w_wr_ptr_b = i_push_a ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
        w_push_n   = (AW+1)'(i_push_a) + (AW+1)'(i_push_b);
    end

    // Storage writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push_a) begin
                r_mem[r_wr_ptr] <= i_data_a;
            end
            if (i_push_b) begin
                r_mem[w_wr_ptr_b] <= i_data_b;
            end
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_n[AW-1:0];
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + w_push_n - (AW+1)'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/vm_vend_ctrl.sv
// Vending transaction controller: coin edge capture into a coin FIFO, one credit
// per cycle, dispense handshake when the price is met, nickel refund on cancel.
// Optional dispense timeout is built when VM_TIMEOUT_EN is defined.
// Handshakes: a request stays high from the edge that raises it until the edge
// on which the matching single-cycle ack is sampled high; acks seen while the
// request is low are ignored.
module vm_vend_ctrl
    import vm_pkg::*;
#(
    parameter int PRICE        = DEFAULT_PRICE,
    parameter int FIFO_DEPTH   = 4,
    parameter int DISP_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       five,
    input  logic       ten,
    input  logic       cancel,
    input  logic       dispense_ack,
    input  logic       change_ack,
    output logic [4:0] balance,
    output logic [1:0] state,
    output logic       dispense_req,
    output logic       change_req,
    output logic       coin_reject,
    output logic       fault
);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [5:0]  PRICE_W = 6'(PRICE);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    vm_state_t      r_state;
    vm_state_t      w_state_nxt;
    logic [4:0]     r_balance;
    logic [4:0]     w_balance_nxt;
    logic [5:0]     w_sum;
    logic           r_five_q;
    logic           r_ten_q;
    logic           r_coin_reject;
    logic           w_five_rise;
    logic           w_ten_rise;
    logic           w_any_rise;
    logic           w_both_rise;
    logic           w_push_a;
    logic           w_push_b;
    logic           w_drop;
    logic           w_pop;
    coin_t          w_data_a;
    coin_t          w_head;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [CW-1:0]  w_fifo_count;
    logic [CW:0]    w_free;
    logic           w_unused;

`ifdef VM_TIMEOUT_EN
    localparam int            TW       = $clog2(DISP_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DISP_TIMEOUT - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_fault;
    logic          w_fault_nxt;
`endif

    // Occupancy is only observed through count; full is kept on the FIFO for reuse.
    assign w_unused = w_fifo_full ^ (DISP_TIMEOUT > 0);

    // Previous button levels for edge detection, and the registered reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_five_q      <= 1'b0;
            r_ten_q       <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_five_q      <= five;
            r_ten_q       <= ten;
            r_coin_reject <= w_drop;
        end
    end

    // Coin capture: nickel goes first when both rise; free space counts this cycle's pop.
    always_comb begin
        w_five_rise = five & ~r_five_q;
        w_ten_rise  = ten & ~r_ten_q;
        w_any_rise  = w_five_rise | w_ten_rise;
        w_both_rise = w_five_rise & w_ten_rise;
        w_data_a    = w_five_rise ? COIN_NICKEL : COIN_DIME;
        w_free      = DEPTH_W - {1'b0, w_fifo_count} + {{CW{1'b0}}, w_pop};
        w_push_a    = w_any_rise && (w_free != '0);
        w_push_b    = w_both_rise && (w_free > (CW+1)'(1));
        w_drop      = (w_any_rise && !w_push_a) || (w_both_rise && !w_push_b);
    end

    vm_coin_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push_a (w_push_a),
        .i_data_a (w_data_a),
        .i_push_b (w_push_b),
        .i_data_b (COIN_DIME),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty),
        .o_count  (w_fifo_count)
    );

    // State and credit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_balance <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_balance <= w_balance_nxt;
        end
    end

    // Next state, credit update, FIFO pop and handshake requests.
    always_comb begin
        w_state_nxt   = r_state;
        w_balance_nxt = r_balance;
        w_sum         = '0;
        w_pop         = 1'b0;
        dispense_req  = 1'b0;
        change_req    = 1'b0;
`ifdef VM_TIMEOUT_EN
        w_fault_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (cancel && (r_balance != '0)) begin
                    w_state_nxt = ST_CHANGE;
                end else if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    w_sum = {1'b0, r_balance} + {1'b0, w_head};
                    if (w_sum >= PRICE_W) begin
                        w_balance_nxt = 5'(w_sum - PRICE_W);
                        w_state_nxt   = ST_VEND;
                    end else begin
                        w_balance_nxt = w_sum[4:0];
                    end
                end
            end
            ST_VEND: begin
                dispense_req = 1'b1;
                if (dispense_ack) begin
                    w_state_nxt = ST_IDLE;
`ifdef VM_TIMEOUT_EN
                end else if (r_tmo_cnt == TMO_LAST) begin
                    // Refund the price; 30 is the largest multiple of 5 that fits.
                    w_fault_nxt   = 1'b1;
                    w_state_nxt   = ST_CHANGE;
                    w_sum         = {1'b0, r_balance} + PRICE_W;
                    w_balance_nxt = (w_sum > 6'd30) ? 5'd30 : w_sum[4:0];
`endif
                end
            end
            ST_CHANGE: begin
                change_req = (r_balance != '0);
                if (r_balance == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (change_ack) begin
                    w_balance_nxt = r_balance - 5'(NICKEL);
                    if (r_balance == 5'(NICKEL)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_balance_nxt = '0;
            end
        endcase
    end

`ifdef VM_TIMEOUT_EN
    // Dispense watchdog: counts consecutive VEND cycles, cleared outside VEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
            if ((r_state == ST_VEND) && (w_state_nxt == ST_VEND)) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign balance     = r_balance;
    assign state       = r_state;
    assign coin_reject = r_coin_reject;

endmodule

// File: tb/tb_vm_vend_ctrl.sv
// Bench for vm_vend_ctrl: vector table, corner-case sequences and random traffic
// against a queue-based reference model. Timeout checks follow VM_TIMEOUT_EN.
module tb_vm_vend_ctrl;
    import vm_pkg::*;

    localparam int PRICE = 25;
    localparam int DEPTH = 4;
    localparam int TMO   = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       five;
    logic       ten;
    logic       cancel;
    logic       dispense_ack;
    logic       change_ack;
    logic [4:0] balance;
    logic [1:0] state;
    logic       dispense_req;
    logic       change_req;
    logic       coin_reject;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    // Reference model: credit, mode (0 idle, 1 vend, 2 change) and queued coins.
    int         m_bal;
    int         m_mode;
    int         m_vcnt;
    logic       m_rej;
    logic       m_fault;
    logic       m_prev5;
    logic       m_prev10;
    logic [4:0] exp_q[$];

    typedef struct {
        logic       f;
        logic       t;
        logic       c;
        logic       da;
        logic       ca;
        logic [4:0] bal;
        logic [1:0] st;
        logic       dreq;
        logic       creq;
    } vec_t;

    vec_t vecs[$];

    vm_vend_ctrl #(
        .PRICE        (PRICE),
        .FIFO_DEPTH   (DEPTH),
        .DISP_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .five         (five),
        .ten          (ten),
        .cancel       (cancel),
        .dispense_ack (dispense_ack),
        .change_ack   (change_ack),
        .balance      (balance),
        .state        (state),
        .dispense_req (dispense_req),
        .change_req   (change_req),
        .coin_reject  (coin_reject),
        .fault        (fault)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic t, input logic c,
                         input logic da, input logic ca);
        five         = f;
        ten          = t;
        cancel       = c;
        dispense_ack = da;
        change_ack   = ca;
    endtask

    task automatic model_reset();
        m_bal    = 0;
        m_mode   = 0;
        m_vcnt   = 0;
        m_rej    = 1'b0;
        m_fault  = 1'b0;
        m_prev5  = 1'b0;
        m_prev10 = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the transaction rules applied to the current inputs.
    task automatic model_step();
        int         nb;
        int         nm;
        int         s;
        logic       drop;
        logic [4:0] v;
        nb      = m_bal;
        nm      = m_mode;
        drop    = 1'b0;
        m_fault = 1'b0;
        if (m_mode == 0) begin
            if (cancel && m_bal > 0) begin
                nm = 2;
            end else if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                s = m_bal + int'(v);
                if (s >= PRICE) begin
                    nb = s - PRICE;
                    nm = 1;
                end else begin
                    nb = s;
                end
            end
        end else if (m_mode == 1) begin
            if (dispense_ack) begin
                nm = 0;
`ifdef VM_TIMEOUT_EN
            end else if (m_vcnt == TMO - 1) begin
                nb      = m_bal + PRICE;
                nm      = 2;
                m_fault = 1'b1;
`endif
            end
        end else begin
            if (change_ack && m_bal > 0) begin
                nb = m_bal - 5;
                if (nb == 0) nm = 0;
            end
        end
        m_vcnt = (m_mode == 1 && nm == 1) ? m_vcnt + 1 : 0;
        if (five && !m_prev5) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(5'd5);
            else drop = 1'b1;
        end
        if (ten && !m_prev10) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(5'd10);
            else drop = 1'b1;
        end
        m_prev5  = five;
        m_prev10 = ten;
        m_rej    = drop;
        m_bal    = nb;
        m_mode   = nm;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".balance"}, {3'b0, balance}, 8'(m_bal));
        chk({tag, ".state"}, {6'b0, state}, 8'(m_mode));
        chk({tag, ".dispense_req"}, {7'b0, dispense_req}, 8'(m_mode == 1));
        chk({tag, ".change_req"}, {7'b0, change_req}, 8'(m_mode == 2 && m_bal > 0));
        chk({tag, ".coin_reject"}, {7'b0, coin_reject}, {7'b0, m_rej});
        chk({tag, ".fault"}, {7'b0, fault}, {7'b0, m_fault});
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic coin(input logic is_dime, input string tag);
        drive(!is_dime, is_dime, 1'b0, 1'b0, 1'b0);
        tick(tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(tag);
    endtask

    task automatic chk_out(input string tag, input int bal, input int st);
        chk({tag, ".exp_balance"}, {3'b0, balance}, 8'(bal));
        chk({tag, ".exp_state"}, {6'b0, state}, 8'(st));
    endtask

    function automatic vec_t mk(input logic f, input logic t, input logic c, input logic da,
                                input logic ca, input int bal, input int st,
                                input logic dreq, input logic creq);
        vec_t v;
        v.f    = f;
        v.t    = t;
        v.c    = c;
        v.da   = da;
        v.ca   = ca;
        v.bal  = 5'(bal);
        v.st   = 2'(st);
        v.dreq = dreq;
        v.creq = creq;
        return v;
    endfunction

    initial begin
        int rej_cnt;
        int vend_seen;
        int fault_seen;

        // Five, ten, ten reaches the price; then 20 + 10 vends with 5 left and refunds it.
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 15, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 15, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 10, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 20, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 20, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  5, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  5, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  5, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));

        // Reset.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;

        // Vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].f, vecs[i].t, vecs[i].c, vecs[i].da, vecs[i].ca);
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_balance", i), {3'b0, balance}, {3'b0, vecs[i].bal});
            chk($sformatf("vec%0d.tbl_state", i), {6'b0, state}, {6'b0, vecs[i].st});
            chk($sformatf("vec%0d.tbl_dispense_req", i), {7'b0, dispense_req}, {7'b0, vecs[i].dreq});
            chk($sformatf("vec%0d.tbl_change_req", i), {7'b0, change_req}, {7'b0, vecs[i].creq});
        end

        // FIFO overflow while the dispense ack is withheld.
        coin(1'b1, "ovf_setup");
        coin(1'b1, "ovf_setup");
        coin(1'b0, "ovf_setup");
        chk_out("ovf.in_vend", 0, 1);
        rej_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(i % 2 == 0, i % 2 == 1, 1'b0, 1'b0, 1'b0);
            tick("ovf");
            rej_cnt += int'(coin_reject);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick("ovf");
            rej_cnt += int'(coin_reject);
        end
        chk("ovf.reject_pulses", 8'(rej_cnt), 8'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("ovf_ack");
        chk_out("ovf.ack", 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("ovf_pop");
        chk_out("ovf.pop1", 5, 0);
        tick("ovf_pop");
        chk_out("ovf.pop2", 15, 0);
        tick("ovf_pop");
        chk_out("ovf.pop3", 20, 0);
        tick("ovf_pop");
        chk_out("ovf.pop4", 5, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("ovf_ack2");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("ovf_cancel");
        chk_out("ovf.cancel", 5, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("ovf_refund");
        chk_out("ovf.refund", 0, 0);

        // Both buttons rise on the same cycle: nickel credited before dime.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("both");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("both");
        chk_out("both.first", 5, 0);
        tick("both");
        chk_out("both.second", 15, 0);

        // Asynchronous reset in the middle of a vend.
        coin(1'b0, "rst_setup");
        coin(1'b1, "rst_setup");
        chk_out("rst.before", 5, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.balance", {3'b0, balance}, 8'd0);
        chk("rst.state", {6'b0, state}, 8'd0);
        chk("rst.dispense_req", {7'b0, dispense_req}, 8'd0);
        chk("rst.change_req", {7'b0, change_req}, 8'd0);
        chk("rst.coin_reject", {7'b0, coin_reject}, 8'd0);
        chk("rst.fault", {7'b0, fault}, 8'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Dispense ack withheld: timeout refund, or an indefinite wait.
        coin(1'b1, "tmo_setup");
        coin(1'b1, "tmo_setup");
        coin(1'b0, "tmo_setup");
        chk_out("tmo.in_vend", 0, 1);
        vend_seen  = 1;
        fault_seen = 0;
`ifdef VM_TIMEOUT_EN
        for (int i = 0; i < 40 && state == 2'd1; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick("tmo");
            if (state == 2'd1) vend_seen++;
            fault_seen += int'(fault);
        end
        chk("tmo.vend_cycles", 8'(vend_seen), 8'(TMO));
        chk("tmo.fault_pulses", 8'(fault_seen), 8'd1);
        chk_out("tmo.refund_start", PRICE, 2);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick("tmo_change");
            chk("tmo.change_balance", {3'b0, balance}, 8'(PRICE - 5 * (k + 1)));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick("tmo_change");
        end
        chk_out("tmo.done", 0, 0);
`else
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick("wait");
            if (state == 2'd1) vend_seen++;
            fault_seen += int'(fault);
        end
        chk("wait.vend_cycles", 8'(vend_seen), 8'd31);
        chk("wait.fault_pulses", 8'(fault_seen), 8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("wait_ack");
        chk_out("wait.ack", 0, 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0);
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
